// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_wr_arbiter.
// The arbiter uses the slave modport; the surrounding environment uses the master modport.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                          enable;
    logic                          clr_err;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_rd_en;
    logic                          fifo_empty;
    logic [CW-1:0]                 credits;
    logic                          busy;
    logic                          err;
    logic [1:0]                    err_code;

    modport slave (
        input  enable, clr_err, req, req_data,
        input  fifo_wr_ack, fifo_overflow, fifo_rd_en, fifo_empty,
        output gnt, fifo_wr_en, fifo_data_in, credits, busy, err, err_code
    );

    modport master (
        output enable, clr_err, req, req_data,
        output fifo_wr_ack, fifo_overflow, fifo_rd_en, fifo_empty,
        input  gnt, fifo_wr_en, fifo_data_in, credits, busy, err, err_code
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with credit-based flow control and ack/overflow checking.
// Define FIFO_ARB_PRIO_EN to give requester 0 fixed top priority over a round-robin among the rest.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   arb_if
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_ERROR  = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  wr_en_q;
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  ack_pend_q;
    logic                  err_q;
    logic [1:0]            err_code_q, err_code_d;
    logic                  busy_q;

    logic [NUM_REQ-1:0]    gnt_s;
    logic [PW-1:0]         win_s;
    logic                  grant_ok_s;
    logic                  grant_s;
    logic                  pop_s;
    logic [1:0]            err_det_s;
    logic [FIFO_WIDTH-1:0] win_data_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
`ifdef FIFO_ARB_PRIO_EN
        if (int'(w) == NUM_REQ - 1) next_ptr = PW'(1);
        else                        next_ptr = w + PW'(1);
`else
        if (int'(w) == NUM_REQ - 1) next_ptr = '0;
        else                        next_ptr = w + PW'(1);
`endif
    endfunction

    assign grant_ok_s = (state_q == ST_ACTIVE) && (credits_q != '0) && (|arb_if.req);
    assign grant_s    = |gnt_s;
    assign pop_s      = arb_if.fifo_rd_en & ~arb_if.fifo_empty;
    assign err_det_s  = {ack_pend_q & ~arb_if.fifo_wr_ack, arb_if.fifo_overflow};
    assign win_data_s = arb_if.req_data[int'(win_s)*FIFO_WIDTH +: FIFO_WIDTH];

    // Winner search starting at rr_ptr and wrapping; yields a one-hot or zero grant
    always_comb begin
        logic found;
        int   idx;
        int   base;
        gnt_s = '0;
        win_s = '0;
        found = 1'b0;
        idx   = 0;
        base  = 0;
        if (grant_ok_s) begin
`ifdef FIFO_ARB_PRIO_EN
            if (arb_if.req[0]) begin
                gnt_s[0] = 1'b1;
            end else begin
                // Pointer value 0 is treated as 1 since requester 0 is outside the rotation
                base = (rr_ptr_q == '0) ? 0 : int'(rr_ptr_q) - 1;
                for (int k = 0; k < NUM_REQ - 1; k++) begin
                    idx = 1 + ((base + k) % (NUM_REQ - 1));
                    if (!found && arb_if.req[idx]) begin
                        found      = 1'b1;
                        gnt_s[idx] = 1'b1;
                        win_s      = idx[PW-1:0];
                    end else begin
                        found = found;
                    end
                end
            end
`else
            base = int'(rr_ptr_q);
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (base + k) % NUM_REQ;
                if (!found && arb_if.req[idx]) begin
                    found      = 1'b1;
                    gnt_s[idx] = 1'b1;
                    win_s      = idx[PW-1:0];
                end else begin
                    found = found;
                end
            end
`endif
        end else begin
            gnt_s = '0;
        end
    end

    // Pointer advance and credit bookkeeping
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        credits_d = credits_q;
`ifdef FIFO_ARB_PRIO_EN
        if (grant_s && (win_s != '0)) rr_ptr_d = next_ptr(win_s);
        else                          rr_ptr_d = rr_ptr_q;
`else
        if (grant_s) rr_ptr_d = next_ptr(win_s);
        else         rr_ptr_d = rr_ptr_q;
`endif
        if (grant_s && !pop_s)                                credits_d = credits_q - CW'(1);
        else if (pop_s && !grant_s && (credits_q != DEPTH_C)) credits_d = credits_q + CW'(1);
        else                                                  credits_d = credits_q;
    end

    // Next-state logic; a fresh error detection beats clr_err
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q | err_det_s;
        if (|err_det_s) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE:   if (arb_if.enable) state_d = ST_ACTIVE; else state_d = ST_IDLE;
                ST_ACTIVE: if (!arb_if.enable) state_d = ST_IDLE; else state_d = ST_ACTIVE;
                ST_ERROR: begin
                    if (arb_if.clr_err) begin
                        state_d    = ST_IDLE;
                        err_code_d = 2'b00;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Arbitration, write-issue and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            credits_q  <= DEPTH_C;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            ack_pend_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            credits_q  <= credits_d;
            wr_en_q    <= grant_s;
            ack_pend_q <= wr_en_q;
            err_code_q <= err_code_d;
            err_q      <= |err_code_d;
            busy_q     <= (state_d == ST_ACTIVE);
            if (grant_s) data_q <= win_data_s;
            else         data_q <= data_q;
        end
    end

    assign arb_if.gnt          = gnt_s;
    assign arb_if.fifo_wr_en   = wr_en_q;
    assign arb_if.fifo_data_in = data_q;
    assign arb_if.credits      = credits_q;
    assign arb_if.busy         = busy_q;
    assign arb_if.err          = err_q;
    assign arb_if.err_code     = err_code_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table plus hand-written error/drain/priority sequences.
// Written data is checked by a scoreboard filled from each expected grant.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int FD = 8;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_nack = 1'b0;
    logic ack_q = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stamp   = 0;
    logic [FW-1:0] exp_q[$];

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       rd;
        logic       empty;
        logic [3:0] gnt;
        logic [3:0] cred;
        logic       busy;
    } vec_t;
    vec_t vecs[$];

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .FIFO_WIDTH(FW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .FIFO_WIDTH(FW)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    // FIFO acknowledge model: ack one cycle after each write unless suppressed
    always @(posedge clk) ack_q <= (bus.fifo_wr_en === 1'b1) && !force_nack;
    assign bus.fifo_wr_ack = ack_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every issued write must match the oldest expected word
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got write %0h expected none", bus.fifo_data_in);
            end else begin
                chk("wr_data", bus.fifo_data_in, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] r);
        stamp++;
        bus.req = r;
        for (int i = 0; i < NR; i++) bus.req_data[i*FW +: FW] = {4'(i), stamp[11:0]};
    endtask

    task automatic push_exp(input logic [3:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) exp_q.push_back(bus.req_data[i*FW +: FW]);
    endtask

    task automatic apply(input logic en, input logic [3:0] r, input logic rd, input logic emp,
                         input logic [3:0] eg, input string nm);
        bus.enable     = en;
        bus.fifo_rd_en = rd;
        bus.fifo_empty = emp;
        drive_req(r);
        #1;
        chk({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
        push_exp(eg);
        tick();
    endtask

    task automatic add(input logic en, input logic [3:0] r, input logic rd, input logic emp,
                       input logic [3:0] g, input logic [3:0] c, input logic b);
        vec_t v;
        v.en = en; v.req = r; v.rd = rd; v.empty = emp; v.gnt = g; v.cred = c; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_a[8];
        logic [3:0] rr_b[8];
        bus.enable = 1'b0; bus.clr_err = 1'b0; bus.fifo_overflow = 1'b0;
        bus.fifo_rd_en = 1'b0; bus.fifo_empty = 1'b1;
        drive_req(4'b0000);

        // en, req, rd, empty | gnt, credits after edge, busy after edge
        add(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd8, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'd7, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0010, 4'd6, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'd5, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, 4'd4, 1'b1);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd4, 1'b1);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'd4, 1'b1);
        add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'd5, 1'b1);
        add(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'd4, 1'b1);
        add(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'd4, 1'b1);
        add(1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 4'd3, 1'b1);
        add(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'd3, 1'b1);
        add(1'b1, 4'b1001, 1'b0, 1'b1, 4'b1000, 4'd2, 1'b1);
        add(1'b1, 4'b1001, 1'b0, 1'b1, 4'b0001, 4'd1, 1'b1);
        add(1'b1, 4'b0110, 1'b0, 1'b1, 4'b0010, 4'd0, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b1);
        add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd1, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'd0, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b1);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'd1, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd2, 1'b0);
        for (int i = 3; i <= 8; i++) add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'(i), 1'b0);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'd8, 1'b0);

        tick(); tick();
        rst = 1'b0;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
        chk("rst_credits", 32'(bus.credits), 32'd8);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].req, vecs[i].rd, vecs[i].empty, vecs[i].gnt, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_credits", i), 32'(bus.credits), 32'(vecs[i].cred));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
        end

        // Drain all credits with a single requester: exactly FD grants
        apply(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, "drain_en");
        for (int k = 0; k < 12; k++) apply(1'b1, 4'b0001, 1'b0, 1'b1, (k < FD) ? 4'b0001 : 4'b0000, "drain");
        chk("drain_credits", 32'(bus.credits), 32'd0);
        chk("drain_err", 32'(bus.err), 32'd0);

        // One returned credit allows exactly one more grant
        apply(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, "ret_pop");
        chk("ret_pop_credits", 32'(bus.credits), 32'd1);
        apply(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, "ret_one");
        chk("ret_one_credits", 32'(bus.credits), 32'd0);
        apply(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000, "ret_none");
        chk("ret_none_credits", 32'(bus.credits), 32'd0);

        // Missing wr_ack -> ST_ERROR, grants blocked, clr_err recovers
        rst = 1'b1;
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "nack_rst");
        rst = 1'b0;
        force_nack = 1'b1;
        apply(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, "nack_en");
        apply(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, "nack_wr");
        apply(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, "nack_wait");
        chk("nack_err_pre", 32'(bus.err), 32'd0);
        apply(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, "nack_det");
        chk("nack_err", 32'(bus.err), 32'd1);
        chk("nack_err_code", 32'(bus.err_code), 32'b10);
        chk("nack_busy", 32'(bus.busy), 32'd0);
        apply(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, "nack_blocked");
        chk("nack_err_hold", 32'(bus.err), 32'd1);
        bus.clr_err = 1'b1;
        apply(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, "nack_clr");
        bus.clr_err = 1'b0;
        force_nack = 1'b0;
        chk("nack_clr_err", 32'(bus.err), 32'd0);
        chk("nack_clr_code", 32'(bus.err_code), 32'd0);
        chk("nack_clr_busy", 32'(bus.busy), 32'd0);
        apply(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, "nack_idle");
        chk("nack_reactive_busy", 32'(bus.busy), 32'd1);
        apply(1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, "nack_resume");
        apply(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0001, "rstmid_wr");

        // Reset while an ack check is pending must discard the check
        force_nack = 1'b1;
        rst = 1'b1;
        apply(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, "rstmid");
        rst = 1'b0;
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "rstmid_a");
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "rstmid_b");
        chk("rstmid_err", 32'(bus.err), 32'd0);
        chk("rstmid_credits", 32'(bus.credits), 32'd8);
        force_nack = 1'b0;

        // Overflow from ST_IDLE; detection wins over clr_err in the same cycle
        bus.fifo_overflow = 1'b1;
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "ovf");
        chk("ovf_err", 32'(bus.err), 32'd1);
        chk("ovf_code", 32'(bus.err_code), 32'b01);
        bus.clr_err = 1'b1;
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "ovf_prec");
        chk("ovf_prec_err", 32'(bus.err), 32'd1);
        chk("ovf_prec_code", 32'(bus.err_code), 32'b01);
        bus.fifo_overflow = 1'b0;
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "ovf_clr");
        bus.clr_err = 1'b0;
        chk("ovf_clr_err", 32'(bus.err), 32'd0);
        chk("ovf_clr_code", 32'(bus.err_code), 32'd0);

        // Rotation with req 1011 then 1010, one pop per cycle keeps credits at 8
`ifdef FIFO_ARB_PRIO_EN
        rr_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
        rr_a = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif
        rr_b = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        apply(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, "rr_en");
        chk("rr_sat_credits", 32'(bus.credits), 32'd8);
        for (int k = 0; k < 8; k++) apply(1'b1, rr_b[k], 1'b1, 1'b0, rr_a[k], $sformatf("rr%0d", k));
        chk("rr_credits", 32'(bus.credits), 32'd8);

        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "end_a");
        apply(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "end_b");
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("end_err", 32'(bus.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
